// File: rtl/control_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// control_sequencer_pkg
//   Shared definitions for the control sequencer of the 8-bit teaching CPU.
//   - Opcode constants, one per instruction (upper nibble of the IR).
//   - T-state encoding: T0..T4 are the instruction steps, HALT is parked at 7
//     so it can never be reached by a plain increment.
//   - strobe_t: the bundle of control strobes driven to the datapath.
//   - effective_opcode(): folds the unassigned opcodes onto NOP or HLT.
// -----------------------------------------------------------------------------
package control_sequencer_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        HALT = 3'd7
    } t_state_e;

    typedef struct packed {
        logic pc_en;
        logic pc_inc;
        logic pc_load;
        logic mar_latch;
        logic ram_en;
        logic ram_latch;
        logic ir_en;
        logic ir_latch;
        logic a_en;
        logic a_latch;
        logic b_latch;
        logic alu_en;
        logic alu_sub;
        logic flags_latch;
        logic out_latch;
    } strobe_t;

    // Opcodes 0x9-0xD have no instruction behind them; they execute either
    // as a harmless NOP or as a HLT so that a runaway program stops.
    function automatic logic [3:0] effective_opcode(input logic [3:0] opcode,
                                                    input logic       halt_on_undef);
        logic [3:0] result;
        result = opcode;
        if (opcode >= 4'h9 && opcode <= 4'hD) begin
            result = halt_on_undef ? OP_HLT : OP_NOP;
        end
        return result;
    endfunction

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// -----------------------------------------------------------------------------
// microcode_rom
//   Purely combinational microcode table. Maps the current step, the opcode
//   and the ALU flags onto the strobe bundle for that step.
//   Ports:
//     opcode      in   4  instruction opcode (meaningful from T2 on)
//     step        in   3  current T-state
//     carry_flag  in   1  carry flag, used by JC
//     zero_flag   in   1  zero flag, used by JZ
//     strobes     out 15  control strobes for this step
//     last_step   out  1  this step ends the instruction (next is T0)
//     halt_step   out  1  this step ends in HALT
// -----------------------------------------------------------------------------
module microcode_rom
    import control_sequencer_pkg::*;
#(
    parameter bit HALT_ON_UNDEF = 1'b0
) (
    input  logic [3:0] opcode,
    input  t_state_e   step,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output strobe_t    strobes,
    output logic       last_step,
    output logic       halt_step
);

    logic [3:0] op;

    // Undefined opcodes are folded away here so the table below only has
    // to know about the real instructions.
    always_comb begin
        op = effective_opcode(opcode, HALT_ON_UNDEF);
    end

    // The microcode table itself. T0/T1 are the common fetch; every step
    // that ends an instruction raises last_step so the counter wraps to T0.
    // Steps past the end of an instruction also report last_step, so an
    // opcode change mid-instruction can never strand the counter.
    always_comb begin
        strobes   = '0;
        last_step = 1'b0;
        halt_step = 1'b0;
        case (step)
            T0: begin
                strobes.pc_en     = 1'b1;
                strobes.mar_latch = 1'b1;
            end
            T1: begin
                strobes.ram_en   = 1'b1;
                strobes.ir_latch = 1'b1;
                strobes.pc_inc   = 1'b1;
            end
            T2: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        strobes.ir_en     = 1'b1;
                        strobes.mar_latch = 1'b1;
                    end
                    OP_LDI: begin
                        strobes.ir_en   = 1'b1;
                        strobes.a_latch = 1'b1;
                        last_step       = 1'b1;
                    end
                    OP_JMP: begin
                        strobes.ir_en   = 1'b1;
                        strobes.pc_load = 1'b1;
                        last_step       = 1'b1;
                    end
                    OP_JC: begin
                        strobes.ir_en   = carry_flag;
                        strobes.pc_load = carry_flag;
                        last_step       = 1'b1;
                    end
                    OP_JZ: begin
                        strobes.ir_en   = zero_flag;
                        strobes.pc_load = zero_flag;
                        last_step       = 1'b1;
                    end
                    OP_OUT: begin
                        strobes.a_en      = 1'b1;
                        strobes.out_latch = 1'b1;
                        last_step         = 1'b1;
                    end
                    OP_HLT: begin
                        halt_step = 1'b1;
                    end
                    default: begin
                        last_step = 1'b1;
                    end
                endcase
            end
            T3: begin
                case (op)
                    OP_LDA: begin
                        strobes.ram_en  = 1'b1;
                        strobes.a_latch = 1'b1;
                        last_step       = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        strobes.ram_en  = 1'b1;
                        strobes.b_latch = 1'b1;
                    end
                    OP_STA: begin
                        strobes.a_en      = 1'b1;
                        strobes.ram_latch = 1'b1;
                        last_step         = 1'b1;
                    end
                    default: begin
                        last_step = 1'b1;
                    end
                endcase
            end
            T4: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    strobes.alu_en      = 1'b1;
                    strobes.a_latch     = 1'b1;
                    strobes.flags_latch = 1'b1;
                    strobes.alu_sub     = (op == OP_SUB);
                end
                last_step = 1'b1;
            end
            default: begin
                last_step = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//   Step counter plus microcode decode for the 8-bit teaching CPU. The T-state
//   register is the only storage; all strobes decode combinationally from it
//   and from the opcode/flags, and the datapath consumes them on the next
//   rising clock edge.
//   Ports:
//     clk                     in   1  single clock, rising edge
//     reset                   in   1  asynchronous, active-high
//     run                     in   1  sequencing enable; low freezes and
//                                     silences all strobes
//     opcode                  in   4  IR upper nibble, valid from T2
//     carry_flag, zero_flag   in   1  flags register
//     pc_en/pc_inc/pc_load    out  1  program counter drive/increment/load
//     mar_latch               out  1  memory address register load
//     ram_en/ram_latch        out  1  RAM drive / RAM write
//     ir_en/ir_latch          out  1  IR operand drive / IR load
//     a_en/a_latch/b_latch    out  1  A drive, A load, B load
//     alu_en/alu_sub          out  1  ALU drive, subtract select
//     flags_latch/out_latch   out  1  flags load, output register load
//     halted                  out  1  high while in HALT
//     t_state                 out  3  0-4 = T0-T4, 7 = HALT
// -----------------------------------------------------------------------------
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter bit HALT_ON_UNDEF = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       pc_en,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_latch,
    output logic       ram_en,
    output logic       ram_latch,
    output logic       ir_en,
    output logic       ir_latch,
    output logic       a_en,
    output logic       a_latch,
    output logic       b_latch,
    output logic       alu_en,
    output logic       alu_sub,
    output logic       flags_latch,
    output logic       out_latch,
    output logic       halted,
    output logic [2:0] t_state
);

    t_state_e state;
    t_state_e next_state;
    strobe_t  rom_strobes;
    strobe_t  strobes;
    logic     last_step;
    logic     halt_step;

    microcode_rom #(
        .HALT_ON_UNDEF(HALT_ON_UNDEF)
    ) u_microcode_rom (
        .opcode     (opcode),
        .step       (state),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .strobes    (rom_strobes),
        .last_step  (last_step),
        .halt_step  (halt_step)
    );

    // Step counter: the single piece of state in the sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= T0;
        end else begin
            state <= next_state;
        end
    end

    // Next step: hold while run is low, stay parked in HALT, otherwise
    // follow the microcode's end-of-instruction and halt markers.
    always_comb begin
        next_state = state;
        if (run) begin
            if (state == HALT) begin
                next_state = HALT;
            end else if (halt_step) begin
                next_state = HALT;
            end else if (last_step) begin
                next_state = T0;
            end else begin
                case (state)
                    T0:      next_state = T1;
                    T1:      next_state = T2;
                    T2:      next_state = T3;
                    T3:      next_state = T4;
                    default: next_state = T0;
                endcase
            end
        end
    end

    // Output gating. The T0 fetch strobes are non-zero, so reset has to mask
    // the strobes directly for them to drop the instant reset rises.
    always_comb begin
        strobes = '0;
        if (run && !reset && state != HALT) begin
            strobes = rom_strobes;
        end
        halted  = (state == HALT) && !reset;
        t_state = state;
    end

    assign pc_en       = strobes.pc_en;
    assign pc_inc      = strobes.pc_inc;
    assign pc_load     = strobes.pc_load;
    assign mar_latch   = strobes.mar_latch;
    assign ram_en      = strobes.ram_en;
    assign ram_latch   = strobes.ram_latch;
    assign ir_en       = strobes.ir_en;
    assign ir_latch    = strobes.ir_latch;
    assign a_en        = strobes.a_en;
    assign a_latch     = strobes.a_latch;
    assign b_latch     = strobes.b_latch;
    assign alu_en      = strobes.alu_en;
    assign alu_sub     = strobes.alu_sub;
    assign flags_latch = strobes.flags_latch;
    assign out_latch   = strobes.out_latch;

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//   Directed bench for control_sequencer. Expected strobe patterns are written
//   out by hand per step; a second instance with HALT_ON_UNDEF=1 covers the
//   undefined-opcode halt. A random run closes out with bus-exclusivity and
//   legal-T-state checks.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

    localparam logic [14:0] S_PC_EN       = 15'h4000;
    localparam logic [14:0] S_PC_INC      = 15'h2000;
    localparam logic [14:0] S_PC_LOAD     = 15'h1000;
    localparam logic [14:0] S_MAR_LATCH   = 15'h0800;
    localparam logic [14:0] S_RAM_EN      = 15'h0400;
    localparam logic [14:0] S_RAM_LATCH   = 15'h0200;
    localparam logic [14:0] S_IR_EN       = 15'h0100;
    localparam logic [14:0] S_IR_LATCH    = 15'h0080;
    localparam logic [14:0] S_A_EN        = 15'h0040;
    localparam logic [14:0] S_A_LATCH     = 15'h0020;
    localparam logic [14:0] S_B_LATCH     = 15'h0010;
    localparam logic [14:0] S_ALU_EN      = 15'h0008;
    localparam logic [14:0] S_ALU_SUB     = 15'h0004;
    localparam logic [14:0] S_FLAGS_LATCH = 15'h0002;
    localparam logic [14:0] S_OUT_LATCH   = 15'h0001;
    localparam logic [14:0] S_NONE        = 15'h0000;
    localparam logic [14:0] S_FETCH0      = S_PC_EN | S_MAR_LATCH;
    localparam logic [14:0] S_FETCH1      = S_RAM_EN | S_IR_LATCH | S_PC_INC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       carry_flag = 1'b0;
    logic       zero_flag = 1'b0;

    logic pc_en, pc_inc, pc_load, mar_latch, ram_en, ram_latch, ir_en, ir_latch;
    logic a_en, a_latch, b_latch, alu_en, alu_sub, flags_latch, out_latch, halted;
    logic [2:0] t_state;

    logic pc_en2, pc_inc2, pc_load2, mar_latch2, ram_en2, ram_latch2, ir_en2, ir_latch2;
    logic a_en2, a_latch2, b_latch2, alu_en2, alu_sub2, flags_latch2, out_latch2, halted2;
    logic [2:0] t_state2;

    logic [18:0] obs1;
    logic [18:0] obs2;

    int num_vectors = 0;
    int num_miscompares = 0;

    always #5 clk = ~clk;

    control_sequencer #(.HALT_ON_UNDEF(1'b0)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .pc_en(pc_en), .pc_inc(pc_inc), .pc_load(pc_load), .mar_latch(mar_latch),
        .ram_en(ram_en), .ram_latch(ram_latch), .ir_en(ir_en), .ir_latch(ir_latch),
        .a_en(a_en), .a_latch(a_latch), .b_latch(b_latch), .alu_en(alu_en),
        .alu_sub(alu_sub), .flags_latch(flags_latch), .out_latch(out_latch),
        .halted(halted), .t_state(t_state)
    );

    control_sequencer #(.HALT_ON_UNDEF(1'b1)) dut_halt (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .pc_en(pc_en2), .pc_inc(pc_inc2), .pc_load(pc_load2), .mar_latch(mar_latch2),
        .ram_en(ram_en2), .ram_latch(ram_latch2), .ir_en(ir_en2), .ir_latch(ir_latch2),
        .a_en(a_en2), .a_latch(a_latch2), .b_latch(b_latch2), .alu_en(alu_en2),
        .alu_sub(alu_sub2), .flags_latch(flags_latch2), .out_latch(out_latch2),
        .halted(halted2), .t_state(t_state2)
    );

    assign obs1 = {t_state, halted, pc_en, pc_inc, pc_load, mar_latch, ram_en, ram_latch,
                   ir_en, ir_latch, a_en, a_latch, b_latch, alu_en, alu_sub,
                   flags_latch, out_latch};
    assign obs2 = {t_state2, halted2, pc_en2, pc_inc2, pc_load2, mar_latch2, ram_en2,
                   ram_latch2, ir_en2, ir_latch2, a_en2, a_latch2, b_latch2, alu_en2,
                   alu_sub2, flags_latch2, out_latch2};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_vectors++;
        if (observed !== expected) begin
            num_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] op,
                                 input logic c, input logic z);
        run        = r;
        opcode     = op;
        carry_flag = c;
        zero_flag  = z;
    endtask

    task automatic checkState(input string tag, input logic [2:0] t, input logic [14:0] s);
        checkOutput(tag, {13'd0, obs1}, {13'd0, t, (t == 3'd7), s});
    endtask

    task automatic expectCycle(input string tag, input logic [2:0] t, input logic [14:0] s);
        checkState(tag, t, s);
        @(negedge clk);
    endtask

    task automatic expectFetch(input string tag);
        expectCycle({tag, "_t0"}, 3'd0, S_FETCH0);
        expectCycle({tag, "_t1"}, 3'd1, S_FETCH1);
    endtask

    initial begin
        int violations;
        int bad_states;

        // Reset held across two edges, then released with run low.
        @(negedge clk);
        @(negedge clk);
        checkState("reset_state", 3'd0, S_NONE);
        reset = 1'b0;
        #1;
        checkState("idle_run_low", 3'd0, S_NONE);
        @(negedge clk);
        checkState("hold_run_low", 3'd0, S_NONE);

        // Undefined opcode 0xB: NOP on the default instance, HLT on the other.
        applyStimulus(1'b1, 4'hB, 1'b0, 1'b0);
        #1;
        checkOutput("undef_halt_t0", {13'd0, obs2}, {13'd0, 3'd0, 1'b0, S_FETCH0});
        expectFetch("undef");
        checkOutput("undef_halt_t2", {13'd0, obs2}, {13'd0, 3'd2, 1'b0, S_NONE});
        expectCycle("undef_nop_t2", 3'd2, S_NONE);
        checkOutput("undef_halt_parked", {13'd0, obs2}, {13'd0, 3'd7, 1'b1, S_NONE});

        // LDI
        applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
        expectFetch("ldi");
        expectCycle("ldi_t2", 3'd2, S_IR_EN | S_A_LATCH);

        // ADD
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
        expectFetch("add");
        expectCycle("add_t2", 3'd2, S_IR_EN | S_MAR_LATCH);
        expectCycle("add_t3", 3'd3, S_RAM_EN | S_B_LATCH);
        expectCycle("add_t4", 3'd4, S_ALU_EN | S_A_LATCH | S_FLAGS_LATCH);

        // SUB
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
        expectFetch("sub");
        expectCycle("sub_t2", 3'd2, S_IR_EN | S_MAR_LATCH);
        expectCycle("sub_t3", 3'd3, S_RAM_EN | S_B_LATCH);
        expectCycle("sub_t4", 3'd4, S_ALU_EN | S_A_LATCH | S_FLAGS_LATCH | S_ALU_SUB);

        // LDA
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
        expectFetch("lda");
        expectCycle("lda_t2", 3'd2, S_IR_EN | S_MAR_LATCH);
        expectCycle("lda_t3", 3'd3, S_RAM_EN | S_A_LATCH);

        // STA
        applyStimulus(1'b1, 4'h4, 1'b0, 1'b0);
        expectFetch("sta");
        expectCycle("sta_t2", 3'd2, S_IR_EN | S_MAR_LATCH);
        expectCycle("sta_t3", 3'd3, S_A_EN | S_RAM_LATCH);

        // JMP
        applyStimulus(1'b1, 4'h6, 1'b0, 1'b0);
        expectFetch("jmp");
        expectCycle("jmp_t2", 3'd2, S_IR_EN | S_PC_LOAD);

        // JC not taken, then taken
        applyStimulus(1'b1, 4'h7, 1'b0, 1'b0);
        expectFetch("jc0");
        expectCycle("jc0_t2", 3'd2, S_NONE);
        applyStimulus(1'b1, 4'h7, 1'b1, 1'b0);
        expectFetch("jc1");
        expectCycle("jc1_t2", 3'd2, S_IR_EN | S_PC_LOAD);

        // JC with carry rising during T2 itself
        applyStimulus(1'b1, 4'h7, 1'b0, 1'b0);
        expectFetch("jcx");
        checkState("jcx_t2_before", 3'd2, S_NONE);
        carry_flag = 1'b1;
        #1;
        checkState("jcx_t2_after", 3'd2, S_IR_EN | S_PC_LOAD);
        @(negedge clk);

        // JZ not taken, then taken
        applyStimulus(1'b1, 4'h8, 1'b1, 1'b0);
        expectFetch("jz0");
        expectCycle("jz0_t2", 3'd2, S_NONE);
        applyStimulus(1'b1, 4'h8, 1'b0, 1'b1);
        expectFetch("jz1");
        expectCycle("jz1_t2", 3'd2, S_IR_EN | S_PC_LOAD);

        // OUT and NOP
        applyStimulus(1'b1, 4'hE, 1'b0, 1'b0);
        expectFetch("out");
        expectCycle("out_t2", 3'd2, S_A_EN | S_OUT_LATCH);
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0);
        expectFetch("nop");
        expectCycle("nop_t2", 3'd2, S_NONE);

        // ADD frozen by run=0 in T3, then resumed
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
        expectFetch("frz");
        expectCycle("frz_t2", 3'd2, S_IR_EN | S_MAR_LATCH);
        run = 1'b0;
        #1;
        checkState("frz_t3_low", 3'd3, S_NONE);
        @(negedge clk);
        checkState("frz_t3_hold", 3'd3, S_NONE);
        run = 1'b1;
        #1;
        checkState("frz_t3_resume", 3'd3, S_RAM_EN | S_B_LATCH);
        @(negedge clk);
        expectCycle("frz_t4", 3'd4, S_ALU_EN | S_A_LATCH | S_FLAGS_LATCH);

        // Reset pulse between edges in ADD T3
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
        expectFetch("rst");
        expectCycle("rst_t2", 3'd2, S_IR_EN | S_MAR_LATCH);
        checkState("rst_t3", 3'd3, S_RAM_EN | S_B_LATCH);
        #1 reset = 1'b1;
        #1 checkState("rst_async", 3'd0, S_NONE);
        #1 reset = 1'b0;
        opcode = 4'h5;
        #1 checkState("rst_refetch_t0", 3'd0, S_FETCH0);
        @(negedge clk);
        expectCycle("rst_refetch_t1", 3'd1, S_FETCH1);
        expectCycle("rst_ldi_t2", 3'd2, S_IR_EN | S_A_LATCH);

        // HLT: parked for 20 cycles regardless of run, then reset out
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
        expectFetch("hlt");
        expectCycle("hlt_t2", 3'd2, S_NONE);
        for (int i = 0; i < 20; i++) begin
            run = (i % 3 != 0);
            #1;
            checkState("hlt_parked", 3'd7, S_NONE);
            @(negedge clk);
        end
        reset = 1'b1;
        #1 checkState("hlt_reset", 3'd0, S_NONE);
        #1 reset = 1'b0;
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkState("hlt_exit_t1", 3'd1, S_FETCH1);

        // Random opcodes (no HLT) with run toggling
        violations = 0;
        bad_states = 0;
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 14)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #1;
            if ($countones({pc_en, ram_en, ir_en, a_en, alu_en}) > 1) violations++;
            if ($countones({pc_en2, ram_en2, ir_en2, a_en2, alu_en2}) > 1) violations++;
            if (t_state == 3'd5 || t_state == 3'd6) bad_states++;
            if (t_state2 == 3'd5 || t_state2 == 3'd6) bad_states++;
            @(negedge clk);
        end
        checkOutput("bus_exclusive", 32'(violations), 32'd0);
        checkOutput("tstate_legal", 32'(bad_states), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter: HALT_ON_UNDEF, default 0, decodes unassigned opcodes as HLT when 1 and as NOP when 0.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; no other reset exists.
REQ-004 run  input  1  sequencing enable; low freezes state and forces every strobe to 0.
REQ-005 opcode  input  4  upper nibble of instruction register; valid from T2.
REQ-006 carry_flag, zero_flag  input  1 each  from flags register.
REQ-007 pc_en, pc_inc, pc_load  output  1 each  program counter bus drive, increment, and load.
REQ-008 mar_latch  output  1  memory-address register load.
REQ-009 ram_en, ram_latch  output  1 each  RAM bus drive and RAM write.
REQ-010 ir_en, ir_latch  output  1 each  instruction register operand drive and load.
REQ-011 a_en, a_latch, b_latch  output  1 each  A register drive, A load, B load.
REQ-012 alu_en, alu_sub, flags_latch  output  1 each  ALU bus drive, subtract select, flags load.
REQ-013 out_latch  output  1  output register load.
REQ-014 halted  output  1  high while in HALT.
REQ-015 t_state  output  3  current step: 0-4 = T0-T4, 7 = HALT.

Function
REQ-016 Strobes shall decode combinationally from the registered t_state and opcode; the registers consume them at the next rising edge.
REQ-017 T0: pc_en, mar_latch. T1: ram_en, ir_latch, pc_inc. These steps are identical for all opcodes.
REQ-018 Execute steps (last listed step returns to T0):
- NOP 0x0: T2 idle.
- LDA 0x1: T2 ir_en+mar_latch; T3 ram_en+a_latch.
- ADD 0x2: T2 ir_en+mar_latch; T3 ram_en+b_latch; T4 alu_en+a_latch+flags_latch.
- SUB 0x3: as ADD, with alu_sub high in T4 only.
- STA 0x4: T2 ir_en+mar_latch; T3 a_en+ram_latch.
- LDI 0x5: T2 ir_en+a_latch.
- JMP 0x6: T2 ir_en+pc_load.
- JC 0x7 and JZ 0x8: T2 ir_en+pc_load only if carry_flag or zero_flag respectively is 1; otherwise T2 idle.
- OUT 0xE: T2 a_en+out_latch.
- HLT 0xF: T2 asserts no strobes; next state is HALT.
REQ-019 Opcodes 0x9-0xD shall behave as NOP when HALT_ON_UNDEF=0 and as HLT when HALT_ON_UNDEF=1.
REQ-020 At most one of pc_en, ram_en, ir_en, a_en, alu_en shall be high in any cycle.
REQ-021 HALT shall be absorbing: all strobes are 0, halted is 1, and only reset exits HALT.
REQ-022 With run=0, t_state shall hold and all strobes shall be 0; on run=1, sequencing resumes at the held step.
REQ-023 Jump-condition flags shall be sampled combinationally in T2; a flag change in T2 affects pc_load in that cycle.
REQ-024 Instruction length (T0 to next T0) shall be: NOP/LDI/JMP/JC/JZ/OUT = 3 cycles, LDA/STA = 4 cycles, ADD/SUB = 5 cycles.

Reset
REQ-025 Asserting reset at any time, including mid-instruction, shall immediately force t_state=0, halted=0, and every strobe to 0, regardless of clk.
REQ-026 After reset deasserts, the first rising edge with run=1 shall advance T0 to T1.

Structure
REQ-027 A shared package shall hold opcode constants, the T-state encoding (T0-T4, HALT=7), and a strobe-bundle typedef.
REQ-028 The step counter shall be the only sequential element; one sub-module, microcode_rom, shall map opcode, step, and flags to the strobe bundle and a last-step bit.

Verification
REQ-029 Reset, run=1, opcode=0x5 -> t_state 0,1,2,0; a_latch and ir_en high only in T2; pc_inc high only in T1.
REQ-030 Opcode=0x2 with run=1 -> five-cycle instruction; b_latch in T3; alu_en+a_latch+flags_latch in T4; alu_sub=0 throughout.
REQ-031 Opcode=0x7: with carry_flag=0, pc_load stays 0 in T2; with carry_flag=1, pc_load=1 in T2; both take 3 cycles.
REQ-032 Opcode=0xF -> halted=1 and t_state=7 from the cycle after T2; stays for 20 cycles; reset returns t_state to 0.
REQ-033 Reset pulse between clock edges during ADD T3 -> outputs go to 0 before the next edge; the next instruction fetch starts at T0.
REQ-034 Random opcodes with run toggling for 10k cycles -> bus-exclusivity (REQ-020) never violated; t_state never takes the values 5 or 6.
